aes_inv_cipher_ctrl: RTL

//  Iterative AES inverse-cipher controller, one round per clock. Accepts a ciphertext block and

---
 rtl/aes_inv_cipher_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one decryption round per clock, round keys fetched by index.
// Defining AES_INV_ABORT_EN adds an `abort` input that cancels an in-flight block.

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] t;
        logic [7:0] m;
        acc = 8'h00;
        t   = x;
        m   = z;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) acc = acc ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
            m = m >> 1;
        end
        return acc;
    endfunction

    logic [7:0] aff;
    logic [7:0] sq;
    logic [7:0] inv;

    // Undo the forward affine map, then invert in GF(2^8) as x^254 (maps 0 to 0).
    always_comb begin
        aff = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        sq  = aff;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign y = inv;
endmodule

module aes_inv_mix_col (
    input  logic [31:0] c,
    output logic [31:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0] s, x2, x4, x8;
        assign s     = c[31-8*i -: 8];
        assign x2    = xt(s);
        assign x4    = xt(x2);
        assign x8    = xt(x4);
        assign m9[i] = x8 ^ s;
        assign mb[i] = x8 ^ x2 ^ s;
        assign md[i] = x8 ^ x4 ^ s;
        assign me[i] = x8 ^ x4 ^ x2;
    end

    for (genvar i = 0; i < 4; i++) begin : g_out
        assign y[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
endmodule

module aes_inv_cipher_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_INV_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      cipher_in,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      plain_out,
    output logic              busy
);
    localparam int unsigned BLK_W = 128;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE} fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [BLK_W-1:0]  state_q, state_d;
    logic [BLK_W-1:0]  plain_q, plain_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;
    logic [KIDX_W-1:0] key_idx_q, key_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [BLK_W-1:0]  isr, isb, ark, imc;
    logic              abort_c;

`ifdef AES_INV_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            localparam int unsigned DST = 4*gc + gr;
            localparam int unsigned SRC = 4*((gc - gr + 4) % 4) + gr;
            assign isr[BLK_W-1-8*DST -: 8] = state_q[BLK_W-1-8*SRC -: 8];
            aes_inv_sbox u_sbox (
                .a (isr[BLK_W-1-8*DST -: 8]),
                .y (isb[BLK_W-1-8*DST -: 8])
            );
        end
        aes_inv_mix_col u_mix (
            .c (ark[BLK_W-1-32*gc -: 32]),
            .y (imc[BLK_W-1-32*gc -: 32])
        );
    end

    assign ark = isb ^ round_key;

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        plain_d   = plain_q;
        rnd_d     = rnd_q;
        key_idx_d = '0;

        if (abort_c && (fsm_q != S_IDLE)) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = cipher_in;
                        rnd_d   = KIDX_W'(NR - 1);
                        fsm_d   = S_INIT;
                    end
                end
                S_INIT: begin
                    state_d = state_q ^ round_key;
                    fsm_d   = S_ROUND;
                end
                S_ROUND: begin
                    state_d = imc;
                    rnd_d   = rnd_q - KIDX_W'(1);
                    if (rnd_q == KIDX_W'(1)) fsm_d = S_FINAL;
                end
                S_FINAL: begin
                    plain_d = ark;
                    fsm_d   = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) fsm_d = S_IDLE;
                end
                default: fsm_d = S_IDLE;
            endcase
        end

        // Handshake/key outputs are registered, so derive them from the next state.
        in_ready_d  = (fsm_d == S_IDLE);
        busy_d      = (fsm_d != S_IDLE);
        out_valid_d = (fsm_d == S_DONE);
        if (fsm_d == S_INIT)       key_idx_d = KIDX_W'(NR);
        else if (fsm_d == S_ROUND) key_idx_d = rnd_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            plain_q     <= '0;
            rnd_q       <= '0;
            key_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            plain_q     <= plain_d;
            rnd_q       <= rnd_d;
            key_idx_q   <= key_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_idx   = key_idx_q;
    assign plain_out = plain_q;
endmodule
